stage_fetch: RTL and testbench

In-order instruction fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues word requests to instruction memory over a ready/valid request channel. Returned words are buffered, with their PCs, in a small queue that the decoder drains under back-pressure. A redirect from execute (branch/jump) flushes the queue and drops responses still in flight.

---
 rtl/stage_fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 76 +++++++
 rtl/stage_fetch.sv | 96 +++++++++
 tb/tb_stage_fetch.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_fetch_pkg.sv
// Shared fetch/decode constants: datapath width, boot PC, instruction size and queue depth.
// Decode imports the same package so both stages agree on these values.
package stage_fetch_pkg;

   localparam int          FETCH_DBITS    = 32;
   localparam logic [31:0] FETCH_START_PC = 32'h0000_0040;
   localparam int          INST_BYTES     = 4;
   localparam int          FETCH_DEPTH    = 4;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, inst} pairs with flush; the head entry is read straight from
// the storage flops, so there is no combinational path from push data to the outputs.
module fetch_queue
   import stage_fetch_pkg::*;
#(
   parameter int DBITS = FETCH_DBITS,
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [DBITS-1:0]          push_pc,
   input  logic [DBITS-1:0]          push_inst,
   input  logic                      pop,
   input  logic                      flush,
   output logic [cnt_w(DEPTH)-1:0]   occupancy,
   output logic [DBITS-1:0]          head_pc,
   output logic [DBITS-1:0]          head_inst
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DBITS-1:0] pc_mem_q   [DEPTH];
   logic [DBITS-1:0] inst_mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    occ_q, occ_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && !flush;
      do_pop   = pop && !flush && (occ_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         occ_d = occ_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         if (do_push) begin
            pc_mem_q[wr_ptr_q]   <= push_pc;
            inst_mem_q[wr_ptr_q] <= push_inst;
         end
      end
   end

   // A simultaneous pop frees the slot the wrapped write pointer lands on.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && !flush && !pop && occ_q == DEPTH_C));

   assign occupancy = occ_q;
   assign head_pc   = pc_mem_q[rd_ptr_q];
   assign head_inst = inst_mem_q[rd_ptr_q];

endmodule

// File: rtl/stage_fetch.sv
// In-order fetch: owns the PC, issues credit-limited word requests, queues returned words
// with their PCs for decode, and on redirect flushes the queue and discards in-flight words.
module stage_fetch
   import stage_fetch_pkg::*;
#(
   parameter int               DBITS    = FETCH_DBITS,
   parameter logic [DBITS-1:0] START_PC = DBITS'(FETCH_START_PC),
   parameter int               DEPTH    = FETCH_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [DBITS-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [DBITS-1:0] imem_rdata,
   input  logic             redirect_valid,
   input  logic [DBITS-1:0] redirect_pc,
   output logic             inst_valid,
   output logic [DBITS-1:0] inst_word,
   output logic [DBITS-1:0] inst_pc,
   input  logic             inst_ready
);

   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [DBITS-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
   logic [CW-1:0]    outstanding_q, outstanding_d, drop_q, drop_d;
   logic [CW-1:0]    occupancy;
   logic [CW:0]      credit;
   logic             accept, push, pop;

   // Registered counts only, so inst_ready never reaches imem_req combinationally.
   assign credit     = {1'b0, outstanding_q} + {1'b0, occupancy};
   assign imem_req   = reset && (credit < DEPTH_C) && !redirect_valid;
   assign accept     = imem_req && imem_ready;
   assign imem_addr  = pc_q;
   assign inst_valid = (occupancy != '0);
   assign pop        = inst_valid && inst_ready && !redirect_valid;

   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      drop_d        = drop_q;
      push          = 1'b0;
      outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);
      if (redirect_valid) begin
         pc_d      = redirect_pc;
         resp_pc_d = redirect_pc;
         // Everything still in flight after this cycle belongs to the old stream.
         drop_d    = outstanding_q - CW'(imem_rvalid);
      end else begin
         if (accept) pc_d = pc_q + DBITS'(INST_BYTES);
         if (imem_rvalid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               push      = 1'b1;
               resp_pc_d = resp_pc_q + DBITS'(INST_BYTES);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= START_PC;
         resp_pc_q     <= START_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fetch_queue #(
      .DBITS (DBITS),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_pc   (resp_pc_q),
      .push_inst (imem_rdata),
      .pop       (pop),
      .flush     (redirect_valid),
      .occupancy (occupancy),
      .head_pc   (inst_pc),
      .head_inst (inst_word)
   );

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch: a latency-L memory responder plus an in-order stream
// model that checks every PC presented to memory and every word consumed by decode.
module tb_stage_fetch;

   localparam logic [31:0] START = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req, imem_ready, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_word, inst_pc;

   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t       pend[$];
   int          cyc = 0, lat = 1, n_acc = 0;
   int          vecs = 0, errs = 0;
   logic [31:0] exp_pc = START, exp_fetch = START;

   stage_fetch #(.DBITS(32), .START_PC(32'h0000_0040), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_word(inst_word), .inst_pc(inst_pc),
      .inst_ready(inst_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check the fetch address and any consumed word, then advance the memory.
   task automatic tick();
      logic acc, rv;
      logic [31:0] a;
      #1;
      acc = reset && imem_req && imem_ready;
      rv  = reset && imem_rvalid;
      a   = imem_addr;
      if (reset) begin
         chk("fetch_addr", imem_addr, exp_fetch);
         if (inst_valid && inst_ready && !redirect_valid) begin
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_word", inst_word, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
         if (redirect_valid) begin
            exp_pc    = redirect_pc;
            exp_fetch = redirect_pc;
         end else if (acc) begin
            exp_fetch = exp_fetch + 32'd4;
         end
      end
      if (acc) n_acc++;
      @(posedge clk);
      if (!reset) begin
         pend.delete();
         exp_pc    = START;
         exp_fetch = START;
      end else begin
         if (rv) void'(pend.pop_front());
         if (acc) pend.push_back('{addr: a, due: cyc + lat});
      end
      cyc++;
      @(negedge clk);
      if (reset && pend.size() > 0 && pend[0].due == cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!inst_valid && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(inst_valid), 32'd1);
   endtask

   initial begin
      int n;
      reset = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

      // Reset state
      @(negedge clk); #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_addr", imem_addr, 32'h40);
      chk("rst_word", inst_word, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);
      tick(); tick();

      // 1: streaming from reset, L = 1
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("stream_req", 32'(imem_req), 32'd1);
         chk("stream_addr", imem_addr, 32'h40 + 32'(4 * k));
         if (k >= 2) begin
            chk("stream_valid", 32'(inst_valid), 32'd1);
            chk("stream_pc", inst_pc, 32'h40 + 32'(4 * (k - 2)));
         end
         tick();
      end

      // 2: decode stall fills the credit window
      inst_ready = 1'b0; n_acc = 0;
      repeat (10) tick();
      #1;
      chk("stall_req_off", 32'(imem_req), 32'd0);
      chk("stall_acc_le_depth", 32'(n_acc <= 4), 32'd1);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      inst_ready = 1'b1;
      repeat (10) tick();

      // 3: redirect to 0x100 with three requests in flight, L = 3
      imem_ready = 1'b0;
      repeat (6) tick();
      chk("drain_empty", 32'(inst_valid), 32'd0);
      lat = 3; imem_ready = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      chk("redir_no_req", 32'(imem_req), 32'd0);
      tick();
      redirect_valid = 1'b0; #1;
      chk("redir_req", 32'(imem_req), 32'd1);
      chk("redir_addr", imem_addr, 32'h100);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("redir_stale_dropped", 32'(inst_valid), 32'd0);
         tick();
      end
      #1;
      chk("redir_first_valid", 32'(inst_valid), 32'd1);
      chk("redir_first_pc", inst_pc, 32'h100);
      chk("redir_first_word", inst_word, mem_word(32'h100));

      // 4: redirect coinciding with a response and a pop
      n = 0;
      while (!(imem_rvalid && inst_valid) && n < 30) begin
         tick();
         n++;
      end
      chk("coinc_setup", 32'(imem_rvalid && inst_valid), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0; #1;
      chk("coinc_empty", 32'(inst_valid), 32'd0);
      chk("coinc_addr", imem_addr, 32'h200);
      wait_valid("coinc_wait");
      chk("coinc_first_pc", inst_pc, 32'h200);
      chk("coinc_first_word", inst_word, mem_word(32'h200));

      // 5: imem_ready toggling, L = 1
      redirect_valid = 1'b1; redirect_pc = 32'h300; imem_ready = 1'b0;
      tick();
      redirect_valid = 1'b0;
      repeat (8) tick();
      lat = 1;
      for (int k = 0; k < 12; k++) begin
         imem_ready = (k % 2 == 0); #1;
         chk("toggle_addr", imem_addr, 32'h300 + 32'(4 * ((k + 1) / 2)));
         tick();
      end
      #1;
      chk("toggle_final_addr", imem_addr, 32'h318);
      imem_ready = 1'b1;
      repeat (4) tick();

      // 6: reset mid-stream
      reset = 1'b0; imem_rvalid = 1'b0; #1;
      chk("midrst_req", 32'(imem_req), 32'd0);
      chk("midrst_valid", 32'(inst_valid), 32'd0);
      chk("midrst_addr", imem_addr, 32'h40);
      chk("midrst_pc", inst_pc, 32'd0);
      tick(); tick();
      reset = 1'b1; #1;
      chk("restart_req", 32'(imem_req), 32'd1);
      chk("restart_addr", imem_addr, 32'h40);
      wait_valid("restart_wait");
      chk("restart_pc", inst_pc, 32'h40);
      repeat (6) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
